// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I definitions for the ID/EX stage: opcode encodings, the canonical NOP,
// and the per-format register-field mask produced by the immediate generator.
package id_ex_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;

    localparam logic [31:0] NOP_ENC  = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    typedef struct packed {
        logic rs1_en;
        logic rs2_en;
        logic rd_en;
    } field_mask_t;

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational RV32I decode helper: instruction format, sign-extended immediate,
// unknown-opcode flag and which register fields the format actually carries.
module imm_gen
    import id_ex_stage_pkg::*;
(
    input  logic [31:0]  instr,
    output logic [31:0]  imm,
    output logic         illegal,
    output field_mask_t  mask,
    output fmt_e         fmt
);

    always_comb begin
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_R:                     fmt = FMT_R;
            default:                  fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        mask    = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b1};
        case (fmt)
            FMT_I: begin
                imm         = {{20{instr[31]}}, instr[31:20]};
                mask.rs2_en = 1'b0;
            end
            FMT_S: begin
                imm        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                mask.rd_en = 1'b0;
            end
            FMT_B: begin
                imm        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                mask.rd_en = 1'b0;
            end
            FMT_U: begin
                imm         = {instr[31:12], 12'b0};
                mask.rs1_en = 1'b0;
                mask.rs2_en = 1'b0;
            end
            FMT_J: begin
                imm         = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                mask.rs1_en = 1'b0;
                mask.rs2_en = 1'b0;
            end
            FMT_R:   imm = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: captures decode-stage fields, immediate and
// register read data (with write-back bypass), supports stall/flush and counts flush bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter bit          BYPASS_EN = 1'b1,
    parameter logic [31:0] NOP_INSTR = NOP_ENC,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      InstrD,
    input  logic             ValidD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  RD1,
    input  logic [XLEN-1:0]  RD2,
    input  logic             RegWriteW,
    input  logic [4:0]       RdW,
    input  logic [XLEN-1:0]  ResultW,
    input  logic             StallE,
    input  logic             FlushE,
    output logic [31:0]      InstrE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             ValidE,
    output logic             IllegalE,
    output logic [CNT_W-1:0] BubbleCnt
);

    logic [31:0]      imm32;
    logic             illegal_dec;
    field_mask_t      mask;
    fmt_e             fmt;
    logic [XLEN-1:0]  rd1_fwd;
    logic [XLEN-1:0]  rd2_fwd;

    imm_gen u_imm_gen (
        .instr   (InstrD),
        .imm     (imm32),
        .illegal (illegal_dec),
        .mask    (mask),
        .fmt     (fmt)
    );

    // Forwarding covers the same-cycle RF write/read race; x0 is never forwarded.
    generate
        if (BYPASS_EN) begin : g_bypass
            assign rd1_fwd = (RegWriteW && RdW != 5'd0 && RdW == InstrD[19:15]) ? ResultW : RD1;
            assign rd2_fwd = (RegWriteW && RdW != 5'd0 && RdW == InstrD[24:20]) ? ResultW : RD2;
        end else begin : g_no_bypass
            assign rd1_fwd = RD1;
            assign rd2_fwd = RD2;
        end
    endgenerate

    logic [31:0]      instr_d, instr_q;
    logic [XLEN-1:0]  pc_d, pc_q, pc4_d, pc4_q;
    logic [XLEN-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [4:0]       rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic             valid_d, valid_q, illegal_d, illegal_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc4_d     = pc4_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (FlushE) begin
            instr_d   = NOP_INSTR;
            pc_d      = '0;
            pc4_d     = '0;
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end else if (!StallE) begin
            instr_d   = InstrD;
            pc_d      = PCD;
            pc4_d     = PCPlus4D;
            rd1_d     = rd1_fwd;
            rd2_d     = rd2_fwd;
            imm_d     = XLEN'($signed(imm32));
            rs1_d     = mask.rs1_en ? InstrD[19:15] : 5'd0;
            rs2_d     = mask.rs2_en ? InstrD[24:20] : 5'd0;
            rd_d      = mask.rd_en  ? InstrD[11:7]  : 5'd0;
            valid_d   = ValidD;
            illegal_d = ValidD && illegal_dec && (fmt == FMT_BAD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pc4_q     <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc4_q     <= pc4_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign InstrE    = instr_q;
    assign PCE       = pc_q;
    assign PCPlus4E  = pc4_q;
    assign RD1E      = rd1_q;
    assign RD2E      = rd2_q;
    assign ImmExtE   = imm_q;
    assign Rs1E      = rs1_q;
    assign Rs2E      = rs2_q;
    assign RdE       = rd_q;
    assign ValidE    = valid_q;
    assign IllegalE  = illegal_q;
    assign BubbleCnt = cnt_q;

endmodule
